// File: rtl/single_pulser.sv
// single_pulser: converts a synchronized, debounced press level
// into exactly one clk-wide pulse per 0->1 transition.
module single_pulser (
    input  logic clk,
    input  logic rst,
    input  logic syncpress_i,
    output logic SP_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next;

    // State register; reset forces IDLE without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; the unused encoding falls back to IDLE.
    always_comb begin
        w_next = IDLE;
        unique case (r_state)
            IDLE:    w_next = syncpress_i ? PULSE : IDLE;
            PULSE:   w_next = syncpress_i ? WAIT  : IDLE;
            WAIT:    w_next = syncpress_i ? WAIT  : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore output: decoded from state only, so no path from syncpress_i.
    always_comb begin
        SP_o = (r_state == PULSE);
    end

endmodule

// File: tb/tb_single_pulser.sv
// tb_single_pulser: directed stimulus with a queue scoreboard
// predicting SP_o from the sampled press level.
module tb_single_pulser;

    logic clk = 1'b0;
    logic rst;
    logic syncpress_i;
    logic SP_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int base;
    logic [31:0] exp_q[$];
    logic m_prev;

    single_pulser dut (
        .clk         (clk),
        .rst         (rst),
        .syncpress_i (syncpress_i),
        .SP_o        (SP_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: drive level, predict, compare after the edge.
    task automatic step(input logic in, input string tag);
        logic [31:0] expv;
        syncpress_i = in;
        exp_q.push_back({31'd0, in & ~m_prev});
        m_prev = in;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            expv = exp_q.pop_front();
            check(tag, {31'd0, SP_o}, expv);
        end
        if (SP_o === 1'b1) pulses++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        syncpress_i = 1'b0;
        m_prev = 1'b0;

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1 check("rst_async", {31'd0, SP_o}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold0", {31'd0, SP_o}, 32'd0);
        syncpress_i = 1'b1;
        @(posedge clk); #1;
        check("rst_ignores_in", {31'd0, SP_o}, 32'd0);
        #1;
        syncpress_i = 1'b0;
        rst = 1'b0;
        m_prev = 1'b0;
        @(negedge clk);
        step(1'b0, "after_rst");

        // Held press for 3 edges.
        step(1'b1, "held_e1");
        step(1'b1, "held_e2");
        step(1'b1, "held_e3");

        // Release then long press.
        step(1'b0, "rel");
        step(1'b1, "long_e1");
        step(1'b1, "long_e2");
        step(1'b1, "long_e3");
        step(1'b1, "long_e4");
        check("two_presses", pulses, 32'd2);

        // Minimum press, then immediate repress.
        step(1'b0, "min_pre");
        step(1'b1, "min_p1");
        step(1'b0, "min_gap");
        step(1'b1, "min_p2");
        step(1'b0, "min_post");
        check("min_pulses", pulses, 32'd4);

        // Reset while in PULSE.
        syncpress_i = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_pulse", {31'd0, SP_o}, 32'd1);
        #1 rst = 1'b1;
        #1 check("rst_mid_pulse", {31'd0, SP_o}, 32'd0);
        m_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, "rel_rst_pulse");
        step(1'b1, "in_wait");

        // Reset while in WAIT, released with press still held.
        rst = 1'b1;
        #1 check("rst_in_wait", {31'd0, SP_o}, 32'd0);
        @(posedge clk); #1;
        check("rst_wait_hold", {31'd0, SP_o}, 32'd0);
        m_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, "rel_rst_wait");
        step(1'b1, "rel_rst_hold");
        step(1'b0, "rel_rst_off");

        // Soak: long idle then long hold.
        base = pulses;
        for (int i = 0; i < 20; i++) step(1'b0, "soak_idle");
        check("soak_idle_cnt", pulses - base, 32'd0);
        for (int i = 0; i < 20; i++) step(1'b1, "soak_hold");
        check("soak_hold_cnt", pulses - base, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
